// File: rtl/regwrite_arbiter.sv
// Two-port register-file writeback arbiter: one-entry buffer per port, round-robin grant,
// registered write outputs. Optional contention counter enabled by ARB_CONFLICT_CNT_EN.
module regwrite_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [63:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [63:0] b_data,
  output logic        b_ready,
  input  logic        hold,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [63:0] WriteData
`ifdef ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  // last_grant | meaning
  // PORT_A     | A won the most recent grant, B has priority next
  // PORT_B     | B won the most recent grant (reset value), A has priority next
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e       last_grant, last_grant_nxt;
  logic        buf_a_valid, buf_b_valid;
  logic [4:0]  buf_a_reg, buf_b_reg;
  logic [63:0] buf_a_data, buf_b_data;
  logic        grant_a, grant_b;
  logic        cap_a, cap_b;

  always_comb begin
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    last_grant_nxt = last_grant;
    if (!hold) begin
      if (buf_a_valid && (!buf_b_valid || last_grant == PORT_B)) begin
        grant_a        = 1'b1;
        last_grant_nxt = PORT_A;
      end else if (buf_b_valid) begin
        grant_b        = 1'b1;
        last_grant_nxt = PORT_B;
      end
    end
  end

  // Ready is gated by reset_n so both ports look busy while reset is held.
  assign a_ready = reset_n & (~buf_a_valid | grant_a);
  assign b_ready = reset_n & (~buf_b_valid | grant_b);
  assign cap_a   = a_valid & a_ready;
  assign cap_b   = b_valid & b_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT_B;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_a_valid <= 1'b0;
      buf_a_reg   <= '0;
      buf_a_data  <= '0;
    end else if (cap_a) begin
      buf_a_valid <= 1'b1;
      buf_a_reg   <= a_reg;
      buf_a_data  <= a_data;
    end else if (grant_a) begin
      buf_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_b_valid <= 1'b0;
      buf_b_reg   <= '0;
      buf_b_data  <= '0;
    end else if (cap_b) begin
      buf_b_valid <= 1'b1;
      buf_b_reg   <= b_reg;
      buf_b_data  <= b_data;
    end else if (grant_b) begin
      buf_b_valid <= 1'b0;
    end
  end

  // Register 31 is consumed like any other write but never enables the decoder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (grant_a) begin
      RegWrite  <= (buf_a_reg != 5'd31);
      WriteReg  <= buf_a_reg;
      WriteData <= buf_a_data;
    end else if (grant_b) begin
      RegWrite  <= (buf_b_reg != 5'd31);
      WriteReg  <= buf_b_reg;
      WriteData <= buf_b_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

`ifdef ARB_CONFLICT_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if (buf_a_valid && buf_b_valid && !hold && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 a_valid / a_reg / a_data  input  1/5/64  ALU writeback request: valid flag, destination register, data.
REQ-005 a_ready  output  1  port A has a free buffer slot.
REQ-006 b_valid / b_reg / b_data / b_ready  same as port A, for the load writeback port.
REQ-007 hold  input  1  freezes grants while asserted, e.g. during a register-file read conflict.
REQ-008 RegWrite  output  1  write enable to the register-file write decoder.
REQ-009 WriteReg  output  5  register index to the decoder.
REQ-010 WriteData  output  64  write data to the register file.
REQ-011 conflict_cnt  output  16  count of contended cycles; present only with ARB_CONFLICT_CNT_EN.

Function
REQ-012 Each port SHALL have a one-entry buffer; x_ready = ~buf_valid_x | grant_x (same-cycle refill allowed).
REQ-013 A request SHALL be captured into its buffer at the rising edge where x_valid & x_ready.
REQ-014 Arbitration SHALL consider buffered entries only, never raw inputs.
REQ-015 When hold=0 and exactly one buffer is valid, that buffer SHALL be granted.
REQ-016 When hold=0 and both buffers are valid, the port not granted last SHALL win (round-robin); a last_grant flop, reset to B, gives A first priority after reset.
REQ-017 When hold=1, no grant SHALL occur, buffers SHALL retain contents, and RegWrite SHALL be 0 on the following cycle.
REQ-018 On a grant, the output registers SHALL load at that edge:
- RegWrite = 1 if the register is not 31, else 0.
- WriteReg = the register index.
- WriteData = the data.
REQ-019 A write to register 31 SHALL be consumed (buffer freed, last_grant updated) but SHALL never assert RegWrite.
REQ-020 Latency SHALL be 2 edges: captured at edge N, granted in cycle N→N+1 and registered at edge N+1, RegWrite high for exactly one cycle.
REQ-021 Throughput SHALL be one write per cycle sustained; with both ports streaming, grants SHALL alternate A,B,A,B.
REQ-022 When no grant occurs, RegWrite SHALL be 0, and WriteReg/WriteData SHALL hold their last values.
REQ-023 Simultaneous grant and new capture on the same port SHALL replace the buffer with the new request without a bubble.
REQ-024 Port A and port B requests to the same register in the same cycle SHALL both be written, in round-robin order; no merging.

Reset
REQ-025 Asserting reset_n low SHALL asynchronously clear:
- both buffer valid flags;
- RegWrite, WriteReg and WriteData (to 0);
- last_grant (to B);
- conflict_cnt (to 0).
REQ-026 While reset_n is low, a_ready and b_ready SHALL be 0.
REQ-027 A reset mid-operation SHALL discard buffered requests without emitting writes.
REQ-028 Ready SHALL return the first cycle after reset_n deasserts.

Configuration
REQ-029 Macro ARB_CONFLICT_CNT_EN:
- Defined: conflict_cnt SHALL increment by 1 each cycle with both buffers valid and hold=0.
- Defined: the counter SHALL saturate at 16'hFFFF.
- Undefined: the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Single request: a_valid=1, a_reg=5, a_data=64'hAA for one cycle -> RegWrite=1, WriteReg=5, WriteData=64'hAA exactly one cycle, 2 edges later.
REQ-031 Contention: A(reg 1) and B(reg 2) every cycle from reset -> WriteReg sequence 1,2,1,2; a_ready and b_ready each high every other cycle; with macro, conflict_cnt increments every cycle.
REQ-032 Register 31: b_reg=31 -> b_ready stays high, RegWrite stays 0, next B request (reg 3) written normally.
REQ-033 Hold: both buffers full, hold=1 for 3 cycles -> RegWrite 0, a_ready=b_ready=0, no state change; on release, A is granted first if B was granted last.
REQ-034 Reset mid-stream: reset_n low with both buffers valid -> RegWrite, WriteReg and WriteData go to 0 immediately; no write occurs after release until new requests arrive.
REQ-035 Saturation (macro defined): force 70000 contended cycles -> conflict_cnt holds 16'hFFFF.
